hm_trn_tx_pktfifo: RTL and testbench

HM_TRN_TX_PKTFIFO -- requirements
Module: hm_trn_tx_pktfifo

---
 rtl/hm_trn_tx_pktfifo.sv | 189 ++++++++++++++++++
 tb/tb_hm_trn_tx_pktfifo.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hm_trn_tx_pktfifo.sv
// Store-and-forward TLP buffer between a local TRN producer and one
// transmit-arbiter master port; partial packets are rewound or dropped.
module hm_trn_tx_pktfifo #(
  parameter int AW = 5
) (
  input  logic          trn_clk,
  input  logic          trn_rst_n,
  input  logic [63:0]   in_td,
  input  logic          in_trem_n,
  input  logic          in_tsof_n,
  input  logic          in_teof_n,
  input  logic          in_tsrc_rdy_n,
  output logic          in_tdst_rdy_n,
  input  logic          m_trn_tdst_rdy_n,
  input  logic          m_trn_terr_drop_n,
  input  logic [5:0]    m_trn_tbuf_av,
  output logic [63:0]   m_trn_td,
  output logic          m_trn_trem_n,
  output logic          m_trn_tsof_n,
  output logic          m_trn_teof_n,
  output logic          m_trn_tsrc_rdy_n,
  output logic          m_trn_tsrc_dsc_n,
  output logic          m_trn_terrfwd_n,
  output logic          m_trn_tstr_n,
  output logic [AW:0]   pkt_cnt,
  output logic          ovf
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    W_IDLE,
    W_PKT,
    W_DISCARD
  } wst_e;

  typedef enum logic {
    R_IDLE,
    R_SEND
  } rst_e;

  // sof is not stored: every committed packet begins at a sof word,
  // so the read side regenerates it from the previous eof transfer.
  logic [65:0] mem_q [DEPTH];

  wst_e        wst_q, wst_d;
  rst_e        rst_q, rst_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] pstart_q, pstart_d;
  logic [AW:0] pkt_cnt_q, pkt_cnt_d;
  logic        commit_q, commit_d;
  logic        ovf_q, ovf_set;
  logic        sof_q, sof_d;
  logic        we;
  logic [AW:0] wa;
  logic [AW:0] used;
  logic        full;
  logic        xfer_in;
  logic        xfer_out;
  logic        out_eof;
  logic [65:0] rd_word;
  logic        unused_terr_drop;

  assign unused_terr_drop = m_trn_terr_drop_n;

  assign used = wr_ptr_q - rd_ptr_q;
  assign full = (used == (AW+1)'(DEPTH));

  assign in_tdst_rdy_n = ~trn_rst_n
                       | (full & (wst_q != W_DISCARD));
  assign xfer_in = ~in_tsrc_rdy_n & ~in_tdst_rdy_n;

  always_comb begin
    wst_d    = wst_q;
    wr_ptr_d = wr_ptr_q;
    pstart_d = pstart_q;
    we       = 1'b0;
    wa       = wr_ptr_q;
    commit_d = 1'b0;
    ovf_set  = 1'b0;
    unique case (wst_q)
      W_IDLE: begin
        if (xfer_in && !in_tsof_n) begin
          pstart_d = wr_ptr_q;
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (!in_teof_n) commit_d = 1'b1;
          else            wst_d    = W_PKT;
        end
      end
      W_PKT: begin
        if (xfer_in) begin
          we = 1'b1;
          if (!in_tsof_n) begin
            wa       = pstart_q;
            wr_ptr_d = pstart_q + 1'b1;
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
          if (!in_teof_n) begin
            commit_d = 1'b1;
            wst_d    = W_IDLE;
          end
        end else if (!in_tsrc_rdy_n && full &&
                     pkt_cnt_q == '0 && !commit_q) begin
          // packet can never fit: drop it rather than deadlock
          wr_ptr_d = pstart_q;
          ovf_set  = 1'b1;
          wst_d    = W_DISCARD;
        end
      end
      W_DISCARD: begin
        if (xfer_in && !in_teof_n) wst_d = W_IDLE;
      end
      default: wst_d = W_IDLE;
    endcase
  end

  assign rd_word  = mem_q[rd_ptr_q[AW-1:0]];
  assign xfer_out = (rst_q == R_SEND) & ~m_trn_tdst_rdy_n;

  always_comb begin
    rst_d    = rst_q;
    rd_ptr_d = rd_ptr_q;
    out_eof  = 1'b0;
    sof_d    = sof_q;
    unique case (rst_q)
      R_IDLE: begin
        if (pkt_cnt_q != '0 && m_trn_tbuf_av != '0) rst_d = R_SEND;
      end
      R_SEND: begin
        if (xfer_out) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          sof_d    = ~rd_word[0];
          if (!rd_word[0]) begin
            out_eof = 1'b1;
            rst_d   = R_IDLE;
          end
        end
      end
      default: rst_d = R_IDLE;
    endcase
  end

  assign pkt_cnt_d = pkt_cnt_q
                   + (AW+1)'(commit_q)
                   - (AW+1)'(out_eof);

  always_ff @(posedge trn_clk or negedge trn_rst_n) begin
    if (!trn_rst_n) begin
      wst_q     <= W_IDLE;
      rst_q     <= R_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      pstart_q  <= '0;
      pkt_cnt_q <= '0;
      commit_q  <= 1'b0;
      ovf_q     <= 1'b0;
      sof_q     <= 1'b1;
    end else begin
      wst_q     <= wst_d;
      rst_q     <= rst_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      pstart_q  <= pstart_d;
      pkt_cnt_q <= pkt_cnt_d;
      commit_q  <= commit_d;
      ovf_q     <= ovf_q | ovf_set;
      sof_q     <= sof_d;
    end
  end

  always_ff @(posedge trn_clk) begin
    if (we) mem_q[wa[AW-1:0]] <= {in_td, in_trem_n, in_teof_n};
  end

  assign m_trn_td         = rd_word[65:2];
  assign m_trn_trem_n     = rd_word[1];
  assign m_trn_teof_n     = rd_word[0];
  assign m_trn_tsof_n     = ~sof_q;
  assign m_trn_tsrc_rdy_n = (rst_q != R_SEND);
  assign m_trn_tsrc_dsc_n = 1'b1;
  assign m_trn_terrfwd_n  = 1'b1;
  assign m_trn_tstr_n     = 1'b1;
  assign pkt_cnt          = pkt_cnt_q;
  assign ovf              = ovf_q;

endmodule

// File: tb/tb_hm_trn_tx_pktfifo.sv
// Directed bench for hm_trn_tx_pktfifo: latency, overflow, rewind,
// back-pressure, tbuf_av gating and mid-packet reset.
module tb_hm_trn_tx_pktfifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] in_td = '0;
  logic        in_trem_n = 1'b1;
  logic        in_tsof_n = 1'b1;
  logic        in_teof_n = 1'b1;
  logic        in_tsrc_rdy_n = 1'b1;
  logic        in_tdst_rdy_n;
  logic        m_tdst_rdy_n = 1'b0;
  logic        m_terr_drop_n = 1'b1;
  logic [5:0]  m_tbuf_av = 6'h3F;
  logic [63:0] m_td;
  logic        m_trem_n, m_tsof_n, m_teof_n, m_tsrc_rdy_n;
  logic        m_dsc_n, m_errfwd_n, m_tstr_n;
  logic [5:0]  pkt_cnt;
  logic        ovf;

  int total = 0;
  int bad = 0;
  int rise_bad = 0;
  logic hold_q = 1'b0;
  logic [66:0] q[$];

  hm_trn_tx_pktfifo #(.AW(5)) dut (
    .trn_clk           (clk),
    .trn_rst_n         (rst_n),
    .in_td             (in_td),
    .in_trem_n         (in_trem_n),
    .in_tsof_n         (in_tsof_n),
    .in_teof_n         (in_teof_n),
    .in_tsrc_rdy_n     (in_tsrc_rdy_n),
    .in_tdst_rdy_n     (in_tdst_rdy_n),
    .m_trn_tdst_rdy_n  (m_tdst_rdy_n),
    .m_trn_terr_drop_n (m_terr_drop_n),
    .m_trn_tbuf_av     (m_tbuf_av),
    .m_trn_td          (m_td),
    .m_trn_trem_n      (m_trem_n),
    .m_trn_tsof_n      (m_tsof_n),
    .m_trn_teof_n      (m_teof_n),
    .m_trn_tsrc_rdy_n  (m_tsrc_rdy_n),
    .m_trn_tsrc_dsc_n  (m_dsc_n),
    .m_trn_terrfwd_n   (m_errfwd_n),
    .m_trn_tstr_n      (m_tstr_n),
    .pkt_cnt           (pkt_cnt),
    .ovf               (ovf)
  );

  always #5 clk = ~clk;

  // output transfer capture and "valid dropped before eof" detector
  always @(posedge clk) begin
    if (!rst_n) begin
      hold_q <= 1'b0;
    end else begin
      if (hold_q && m_tsrc_rdy_n) rise_bad <= rise_bad + 1;
      hold_q <= !m_tsrc_rdy_n && !(!m_tdst_rdy_n && !m_teof_n);
      if (!m_tsrc_rdy_n && !m_tdst_rdy_n)
        q.push_back({m_td, m_trem_n, m_tsof_n, m_teof_n});
    end
  end

  function automatic logic [66:0] exp_w(input logic [63:0] d,
                                        input logic sof,
                                        input logic eof);
    return {d, ~eof ? 1'b0 : 1'b1, ~sof, ~eof};
  endfunction

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [63:0] d,
                           input logic sof,
                           input logic eof);
    int n;
    in_td = d;
    in_trem_n = eof;
    in_tsof_n = ~sof;
    in_teof_n = ~eof;
    in_tsrc_rdy_n = 1'b0;
    n = 0;
    while (in_tdst_rdy_n && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (n >= 100) begin
      $display("FAIL send_timeout word=%h got tdst_rdy_n=1 need 0", d);
      bad++;
    end else begin
      @(posedge clk);
      #1;
    end
    in_tsrc_rdy_n = 1'b1;
  endtask

  task automatic wait_out(input int n);
    int c;
    c = 0;
    while (q.size() < n && c < 200) begin
      @(posedge clk);
      #1;
      c++;
    end
  endtask

  task automatic test_reset;
    cycles(2);
    total++;
    if (m_tsrc_rdy_n !== 1'b1) begin
      $display("FAIL rst_tsrc got %b need 1", m_tsrc_rdy_n); bad++;
    end
    total++;
    if (in_tdst_rdy_n !== 1'b1) begin
      $display("FAIL rst_tdst got %b need 1", in_tdst_rdy_n); bad++;
    end
    total++;
    if (pkt_cnt !== 6'd0) begin
      $display("FAIL rst_pktcnt got %0d need 0", pkt_cnt); bad++;
    end
    total++;
    if (ovf !== 1'b0) begin
      $display("FAIL rst_ovf got %b need 0", ovf); bad++;
    end
    total++;
    if ({m_dsc_n, m_errfwd_n, m_tstr_n} !== 3'b111) begin
      $display("FAIL const_outs got %b need 111",
               {m_dsc_n, m_errfwd_n, m_tstr_n}); bad++;
    end
    rst_n = 1'b1;
    cycles(1);
  endtask

  task automatic test_single;
    logic [66:0] e;
    q.delete();
    m_tdst_rdy_n = 1'b0;
    m_tbuf_av = 6'h3F;
    for (int i = 0; i < 4; i++)
      send_word(64'h1000 + 64'(i), i == 0, i == 3);
    total++;
    if (m_tsrc_rdy_n !== 1'b1 || pkt_cnt !== 6'd0) begin
      $display("FAIL single_e0 got rdy=%b cnt=%0d need 1/0",
               m_tsrc_rdy_n, pkt_cnt); bad++;
    end
    cycles(1);
    total++;
    if (m_tsrc_rdy_n !== 1'b1 || pkt_cnt !== 6'd1) begin
      $display("FAIL single_e1 got rdy=%b cnt=%0d need 1/1",
               m_tsrc_rdy_n, pkt_cnt); bad++;
    end
    cycles(1);
    for (int i = 0; i < 4; i++) begin
      e = exp_w(64'h1000 + 64'(i), i == 0, i == 3);
      total++;
      if (m_tsrc_rdy_n !== 1'b0 ||
          {m_td, m_trem_n, m_tsof_n, m_teof_n} !== e) begin
        $display("FAIL single_w%0d got rdy=%b w=%h need 0 %h", i,
                 m_tsrc_rdy_n, {m_td, m_trem_n, m_tsof_n, m_teof_n}, e);
        bad++;
      end
      cycles(1);
    end
    total++;
    if (m_tsrc_rdy_n !== 1'b1 || pkt_cnt !== 6'd0) begin
      $display("FAIL single_end got rdy=%b cnt=%0d need 1/0",
               m_tsrc_rdy_n, pkt_cnt); bad++;
    end
  endtask

  task automatic test_rewind;
    q.delete();
    for (int i = 0; i < 3; i++) send_word(64'hA0 + 64'(i), i == 0, 1'b0);
    for (int i = 0; i < 3; i++) send_word(64'hB0 + 64'(i), i == 0, i == 2);
    wait_out(3);
    cycles(5);
    total++;
    if (q.size() != 3) begin
      $display("FAIL rewind_cnt got %0d need 3", q.size()); bad++;
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (q[i] !== exp_w(64'hB0 + 64'(i), i == 0, i == 2)) begin
          $display("FAIL rewind_w%0d got %h need %h", i, q[i],
                   exp_w(64'hB0 + 64'(i), i == 0, i == 2));
          bad++;
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] d [4];
    d[0] = 64'h10; d[1] = 64'h11; d[2] = 64'h20; d[3] = 64'h21;
    q.delete();
    rise_bad = 0;
    m_tdst_rdy_n = 1'b1;
    for (int i = 0; i < 4; i++) send_word(d[i], i % 2 == 0, i % 2 == 1);
    cycles(3);
    total++;
    if (pkt_cnt !== 6'd2) begin
      $display("FAIL b2b_pktcnt got %0d need 2", pkt_cnt); bad++;
    end
    for (int i = 0; i < 24; i++) begin
      m_tdst_rdy_n = ~m_tdst_rdy_n;
      cycles(1);
    end
    m_tdst_rdy_n = 1'b0;
    cycles(2);
    total++;
    if (q.size() != 4) begin
      $display("FAIL b2b_cnt got %0d need 4", q.size()); bad++;
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (q[i] !== exp_w(d[i], i % 2 == 0, i % 2 == 1)) begin
          $display("FAIL b2b_w%0d got %h need %h", i, q[i],
                   exp_w(d[i], i % 2 == 0, i % 2 == 1));
          bad++;
        end
      end
    end
    total++;
    if (rise_bad != 0) begin
      $display("FAIL b2b_rise got %0d need 0", rise_bad); bad++;
    end
  endtask

  task automatic test_tbuf_av;
    q.delete();
    m_tbuf_av = 6'h00;
    send_word(64'hC0FFEE, 1'b1, 1'b1);
    cycles(5);
    total++;
    if (m_tsrc_rdy_n !== 1'b1 || pkt_cnt !== 6'd1) begin
      $display("FAIL tbuf0 got rdy=%b cnt=%0d need 1/1",
               m_tsrc_rdy_n, pkt_cnt); bad++;
    end
    m_tbuf_av = 6'h01;
    cycles(1);
    total++;
    if (m_tsrc_rdy_n !== 1'b0) begin
      $display("FAIL tbuf1 got rdy=%b need 0", m_tsrc_rdy_n); bad++;
    end
    wait_out(1);
    cycles(1);
    total++;
    if (q.size() != 1 || q[0] !== exp_w(64'hC0FFEE, 1'b1, 1'b1)) begin
      $display("FAIL tbuf_word got n=%0d need 1 word %h", q.size(),
               exp_w(64'hC0FFEE, 1'b1, 1'b1)); bad++;
    end
    m_tbuf_av = 6'h3F;
  endtask

  task automatic test_overflow;
    q.delete();
    for (int i = 0; i < 40; i++) begin
      if (i == 32) begin
        total++;
        if (ovf !== 1'b0 || in_tdst_rdy_n !== 1'b1) begin
          $display("FAIL ovf_full got ovf=%b tdst=%b need 0/1",
                   ovf, in_tdst_rdy_n); bad++;
        end
      end
      send_word(64'h5000 + 64'(i), i == 0, i == 39);
      if (i == 32) begin
        total++;
        if (ovf !== 1'b1) begin
          $display("FAIL ovf_set got %b need 1", ovf); bad++;
        end
      end
    end
    cycles(5);
    total++;
    if (pkt_cnt !== 6'd0 || q.size() != 0 || m_tsrc_rdy_n !== 1'b1) begin
      $display("FAIL ovf_quiet got cnt=%0d out=%0d rdy=%b need 0/0/1",
               pkt_cnt, q.size(), m_tsrc_rdy_n); bad++;
    end
    send_word(64'hABC, 1'b1, 1'b1);
    wait_out(1);
    cycles(1);
    total++;
    if (q.size() != 1 || q[0] !== exp_w(64'hABC, 1'b1, 1'b1)) begin
      $display("FAIL ovf_after got n=%0d need 1 word %h", q.size(),
               exp_w(64'hABC, 1'b1, 1'b1)); bad++;
    end
    total++;
    if (ovf !== 1'b1) begin
      $display("FAIL ovf_sticky got %b need 1", ovf); bad++;
    end
  endtask

  task automatic test_reset_mid;
    int c;
    q.delete();
    m_tdst_rdy_n = 1'b1;
    for (int i = 0; i < 3; i++) send_word(64'h700 + 64'(i), i == 0, i == 2);
    c = 0;
    while (m_tsrc_rdy_n && c < 10) begin
      cycles(1);
      c++;
    end
    m_tdst_rdy_n = 1'b0;
    cycles(1);
    total++;
    if (q.size() != 1) begin
      $display("FAIL mid_pre got %0d need 1", q.size()); bad++;
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (m_tsrc_rdy_n !== 1'b1 || pkt_cnt !== 6'd0 ||
        ovf !== 1'b0 || in_tdst_rdy_n !== 1'b1) begin
      $display("FAIL mid_rst got rdy=%b cnt=%0d ovf=%b tdst=%b need 1/0/0/1",
               m_tsrc_rdy_n, pkt_cnt, ovf, in_tdst_rdy_n); bad++;
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycles(1);
    q.delete();
    send_word(64'h701, 1'b0, 1'b0);
    send_word(64'h702, 1'b0, 1'b1);
    cycles(6);
    total++;
    if (q.size() != 0 || pkt_cnt !== 6'd0 || m_tsrc_rdy_n !== 1'b1) begin
      $display("FAIL mid_quiet got out=%0d cnt=%0d rdy=%b need 0/0/1",
               q.size(), pkt_cnt, m_tsrc_rdy_n); bad++;
    end
    send_word(64'h800, 1'b1, 1'b0);
    send_word(64'h801, 1'b0, 1'b1);
    wait_out(2);
    cycles(1);
    total++;
    if (q.size() != 2 || q[0] !== exp_w(64'h800, 1'b1, 1'b0) ||
        q[1] !== exp_w(64'h801, 1'b0, 1'b1)) begin
      $display("FAIL mid_new got n=%0d w0=%h need 2 words", q.size(),
               q.size() > 0 ? q[0] : 67'h0); bad++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rewind();
    test_back_to_back();
    test_tbuf_av();
    test_overflow();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
